// File: rtl/midi_pkg.sv
// Shared MIDI constants, RX state encoding and the status-to-length helper
// used by the serial receiver and the message parser.
package midi_pkg;

    localparam logic [7:0] NOTE_OFF = 8'h80;
    localparam logic [7:0] PROG_CHG = 8'hC0;
    localparam logic [7:0] CHAN_AT  = 8'hD0;
    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] MTC_QF   = 8'hF1;
    localparam logic [7:0] SONG_POS = 8'hF2;
    localparam logic [7:0] SONG_SEL = 8'hF3;
    localparam logic [7:0] TUNE_REQ = 8'hF6;
    localparam logic [7:0] EOX      = 8'hF7;
    localparam logic [7:0] RT_MIN   = 8'hF8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Number of data bytes that follow a status byte; 0 for anything without data.
    function automatic logic [1:0] data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        if (status[7:4] == PROG_CHG[7:4] || status[7:4] == CHAN_AT[7:4]) begin
            len = 2'd1;
        end else if (status >= NOTE_OFF && status < SYSEX) begin
            len = 2'd2;
        end else if (status == MTC_QF || status == SONG_SEL) begin
            len = 2'd1;
        end else if (status == SONG_POS) begin
            len = 2'd2;
        end
        return len;
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, start/data/stop FSM and bit timer.
// Produces a one-cycle byte strobe or a one-cycle framing error per frame.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int DIV = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       midi_in,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       frame_err
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic            sync1_q, sync2_q;
    logic [1:0]      settle_q, settle_d;
    logic            seenHigh_q, seenHigh_d;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byteStb_q, byteStb_d;
    logic            frameErr_q, frameErr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            settle_q   <= 2'b00;
            seenHigh_q <= 1'b0;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= 3'd0;
            shift_q    <= 8'h00;
            byteStb_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            sync1_q    <= midi_in;
            sync2_q    <= sync1_q;
            settle_q   <= settle_d;
            seenHigh_q <= seenHigh_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            byteStb_q  <= byteStb_d;
            frameErr_q <= frameErr_d;
        end
    end

    // settle_q masks the reset value still held in the synchronizer, so a line
    // that is low when reset releases cannot be mistaken for a start edge.
    always_comb begin
        settle_d   = {settle_q[0], 1'b1};
        seenHigh_d = seenHigh_q;
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        byteStb_d  = 1'b0;
        frameErr_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (settle_q[1] && sync2_q) begin
                    seenHigh_d = 1'b1;
                end
                if (seenHigh_q && !sync2_q) begin
                    seenHigh_d = 1'b0;
                    state_d    = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d    = '0;
                    bitIdx_d = 3'd0;
                    state_d  = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    shift_d  = {sync2_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        byteStb_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte   = shift_q;
    assign byte_stb  = byteStb_q;
    assign frame_err = frameErr_q;

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream receiver and message assembler with running status,
// SysEx discard and a one-entry valid/ready output register.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 31250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       midi_in,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = CLK_HZ / BAUD;

    logic [7:0] rxByte;
    logic       byteStb;

    midi_uart_rx #(
        .DIV(DIV)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .midi_in  (midi_in),
        .rx_byte  (rxByte),
        .byte_stb (byteStb),
        .frame_err(frame_err)
    );

    logic [7:0] curStatus_q, curStatus_d;
    logic       curValid_q, curValid_d;
    logic [1:0] expLen_q, expLen_d;
    logic [1:0] cnt_q, cnt_d;
    logic [6:0] data1_q, data1_d;
    logic       inSysex_q, inSysex_d;

    logic       outValid_q, outValid_d;
    logic [7:0] outStatus_q, outStatus_d;
    logic [6:0] outData1_q, outData1_d;
    logic [6:0] outData2_q, outData2_d;
    logic [1:0] outLen_q, outLen_d;
    logic       overrun_q, overrun_d;

    logic       newValid;
    logic [7:0] newStatus;
    logic [6:0] newData1, newData2;
    logic [1:0] newLen;
    logic       canLoad;

    always_ff @(posedge clk) begin
        if (reset) begin
            curStatus_q <= 8'h00;
            curValid_q  <= 1'b0;
            expLen_q    <= 2'd0;
            cnt_q       <= 2'd0;
            data1_q     <= 7'h00;
            inSysex_q   <= 1'b0;
            outValid_q  <= 1'b0;
            outStatus_q <= 8'h00;
            outData1_q  <= 7'h00;
            outData2_q  <= 7'h00;
            outLen_q    <= 2'd0;
            overrun_q   <= 1'b0;
        end else begin
            curStatus_q <= curStatus_d;
            curValid_q  <= curValid_d;
            expLen_q    <= expLen_d;
            cnt_q       <= cnt_d;
            data1_q     <= data1_d;
            inSysex_q   <= inSysex_d;
            outValid_q  <= outValid_d;
            outStatus_q <= outStatus_d;
            outData1_q  <= outData1_d;
            outData2_q  <= outData2_d;
            outLen_q    <= outLen_d;
            overrun_q   <= overrun_d;
        end
    end

    // System-common statuses reuse curStatus as a one-shot holder; curValid is
    // dropped after their message so they never act as running status.
    always_comb begin
        curStatus_d = curStatus_q;
        curValid_d  = curValid_q;
        expLen_d    = expLen_q;
        cnt_d       = cnt_q;
        data1_d     = data1_q;
        inSysex_d   = inSysex_q;
        newValid    = 1'b0;
        newStatus   = 8'h00;
        newData1    = 7'h00;
        newData2    = 7'h00;
        newLen      = 2'd0;
        if (byteStb) begin
            if (rxByte >= RT_MIN) begin
                newValid  = 1'b1;
                newStatus = rxByte;
            end else if (rxByte[7]) begin
                cnt_d = 2'd0;
                if (rxByte < SYSEX) begin
                    curStatus_d = rxByte;
                    curValid_d  = 1'b1;
                    expLen_d    = data_len(rxByte);
                    inSysex_d   = 1'b0;
                end else if (rxByte == SYSEX) begin
                    inSysex_d  = 1'b1;
                    curValid_d = 1'b0;
                end else if (rxByte == EOX) begin
                    inSysex_d = 1'b0;
                end else if (rxByte == TUNE_REQ) begin
                    curValid_d = 1'b0;
                    newValid   = 1'b1;
                    newStatus  = rxByte;
                end else if (data_len(rxByte) != 2'd0) begin
                    curStatus_d = rxByte;
                    curValid_d  = 1'b1;
                    expLen_d    = data_len(rxByte);
                end else begin
                    curValid_d = 1'b0;
                end
            end else if (!inSysex_q && curValid_q) begin
                if (cnt_q == 2'd0 && expLen_q == 2'd2) begin
                    data1_d = rxByte[6:0];
                    cnt_d   = 2'd1;
                end else begin
                    newValid  = 1'b1;
                    newStatus = curStatus_q;
                    newLen    = expLen_q;
                    cnt_d     = 2'd0;
                    if (expLen_q == 2'd1) begin
                        newData1 = rxByte[6:0];
                    end else begin
                        newData1 = data1_q;
                        newData2 = rxByte[6:0];
                    end
                    if (curStatus_q >= SYSEX) begin
                        curValid_d = 1'b0;
                    end
                end
            end
        end
    end

    // A message may replace the held one only in the cycle it is accepted.
    assign canLoad = !outValid_q || msg_ready;

    always_comb begin
        outValid_d  = outValid_q;
        outStatus_d = outStatus_q;
        outData1_d  = outData1_q;
        outData2_d  = outData2_q;
        outLen_d    = outLen_q;
        overrun_d   = newValid && !canLoad;
        if (newValid && canLoad) begin
            outValid_d  = 1'b1;
            outStatus_d = newStatus;
            outData1_d  = newData1;
            outData2_d  = newData2;
            outLen_d    = newLen;
        end else if (outValid_q && msg_ready) begin
            outValid_d = 1'b0;
        end
    end

    assign msg_valid  = outValid_q;
    assign msg_status = outStatus_q;
    assign msg_data1  = outData1_q;
    assign msg_data2  = outData2_q;
    assign msg_len    = outLen_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser at DIV = 32: builds serial frames,
// logs accepted messages and checks them against hand-computed values.
module tb_midi_msg_parser;

    logic       clk;
    logic       reset;
    logic       midi_in;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic [1:0] msg_len;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int passed = 0;

    logic [23:0] accLog [0:63];
    int          accCount = 0;
    int          feCount  = 0;
    int          ovCount  = 0;

    midi_msg_parser #(
        .CLK_HZ(1_000_000),
        .BAUD  (31250)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .midi_in   (midi_in),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_status(msg_status),
        .msg_data1 (msg_data1),
        .msg_data2 (msg_data2),
        .msg_len   (msg_len),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake and pulse, sampled half a cycle from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (msg_valid && msg_ready) begin
                if (accCount < 64) begin
                    accLog[accCount] <= {msg_status, msg_data1, msg_data2, msg_len};
                end
                accCount <= accCount + 1;
            end
            if (frame_err) feCount <= feCount + 1;
            if (overrun)   ovCount <= ovCount + 1;
        end
    end

    function automatic logic [23:0] pack(input logic [7:0] s, input logic [6:0] d1,
                                         input logic [6:0] d2, input logic [1:0] len);
        return {s, d1, d2, len};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBits(input logic [7:0] b, input logic stopBit);
        midi_in = 1'b0;
        tick(32);
        for (int i = 0; i < 8; i++) begin
            midi_in = b[i];
            tick(32);
        end
        midi_in = stopBit;
        tick(32);
        midi_in = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        sendBits(b, 1'b1);
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        midi_in   = 1'b1;
        msg_ready = 1'b1;
        tick(3);
        checks++; if (msg_valid !== 1'b0) $display("[TB] FAIL reset_valid got %0b want 0", msg_valid); else passed++;
        checks++; if (msg_status !== 8'h00) $display("[TB] FAIL reset_status got %h want 00", msg_status); else passed++;
        checks++; if (msg_data1 !== 7'h00) $display("[TB] FAIL reset_data1 got %h want 00", msg_data1); else passed++;
        checks++; if (msg_data2 !== 7'h00) $display("[TB] FAIL reset_data2 got %h want 00", msg_data2); else passed++;
        checks++; if (msg_len !== 2'd0) $display("[TB] FAIL reset_len got %0d want 0", msg_len); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err got %0b want 0", frame_err); else passed++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun got %0b want 0", overrun); else passed++;
        reset = 1'b0;
        tick(10);
    endtask

    task automatic test_single_note;
        int base;
        base      = accCount;
        msg_ready = 1'b0;
        sendByte(8'h90);
        sendByte(8'h3C);
        midi_in = 1'b0;
        tick(32);
        for (int i = 0; i < 8; i++) begin
            midi_in = (8'h64 >> i) & 8'h01 ? 1'b1 : 1'b0;
            tick(32);
        end
        midi_in = 1'b1;
        // Stop sample sits near the middle of the stop bit (cycle ~304 of the frame).
        tick(12);
        checks++; if (msg_valid !== 1'b0) $display("[TB] FAIL note_early_valid got %0b want 0", msg_valid); else passed++;
        tick(20);
        checks++; if (msg_valid !== 1'b1) $display("[TB] FAIL note_valid got %0b want 1", msg_valid); else passed++;
        checks++; if (msg_status !== 8'h90) $display("[TB] FAIL note_status got %h want 90", msg_status); else passed++;
        checks++; if (msg_data1 !== 7'h3C) $display("[TB] FAIL note_data1 got %h want 3c", msg_data1); else passed++;
        checks++; if (msg_data2 !== 7'h64) $display("[TB] FAIL note_data2 got %h want 64", msg_data2); else passed++;
        checks++; if (msg_len !== 2'd2) $display("[TB] FAIL note_len got %0d want 2", msg_len); else passed++;
        tick(40);
        checks++; if (msg_valid !== 1'b1 || msg_data2 !== 7'h64) $display("[TB] FAIL note_hold got v=%0b d2=%h want v=1 d2=64", msg_valid, msg_data2); else passed++;
        msg_ready = 1'b1;
        tick(1);
        checks++; if (msg_valid !== 1'b0) $display("[TB] FAIL note_accept_valid got %0b want 0", msg_valid); else passed++;
        checks++; if (accCount - base !== 1) $display("[TB] FAIL note_accept_count got %0d want 1", accCount - base); else passed++;
        tick(10);
    endtask

    task automatic test_running_status;
        int base;
        base = accCount;
        sendByte(8'h90);
        sendByte(8'h3C);
        sendByte(8'h64);
        sendByte(8'h40);
        sendByte(8'h00);
        tick(40);
        checks++; if (accCount - base !== 2) $display("[TB] FAIL rs_count got %0d want 2", accCount - base); else passed++;
        checks++; if (accLog[base] !== pack(8'h90, 7'h3C, 7'h64, 2'd2)) $display("[TB] FAIL rs_msg0 got %h want %h", accLog[base], pack(8'h90, 7'h3C, 7'h64, 2'd2)); else passed++;
        checks++; if (accLog[base+1] !== pack(8'h90, 7'h40, 7'h00, 2'd2)) $display("[TB] FAIL rs_msg1 got %h want %h", accLog[base+1], pack(8'h90, 7'h40, 7'h00, 2'd2)); else passed++;
    endtask

    task automatic test_realtime;
        int base;
        base = accCount;
        sendByte(8'h90);
        sendByte(8'h3C);
        sendByte(8'hF8);
        sendByte(8'h64);
        tick(40);
        checks++; if (accCount - base !== 2) $display("[TB] FAIL rt_count got %0d want 2", accCount - base); else passed++;
        checks++; if (accLog[base] !== pack(8'hF8, 7'h00, 7'h00, 2'd0)) $display("[TB] FAIL rt_msg0 got %h want %h", accLog[base], pack(8'hF8, 7'h00, 7'h00, 2'd0)); else passed++;
        checks++; if (accLog[base+1] !== pack(8'h90, 7'h3C, 7'h64, 2'd2)) $display("[TB] FAIL rt_msg1 got %h want %h", accLog[base+1], pack(8'h90, 7'h3C, 7'h64, 2'd2)); else passed++;
    endtask

    task automatic test_overrun;
        int base, ovBase;
        base      = accCount;
        ovBase    = ovCount;
        msg_ready = 1'b0;
        sendByte(8'h90);
        sendByte(8'h3C);
        sendByte(8'hF8);
        sendByte(8'h64);
        tick(40);
        checks++; if (ovCount - ovBase !== 1) $display("[TB] FAIL ov_pulses got %0d want 1", ovCount - ovBase); else passed++;
        checks++; if (msg_valid !== 1'b1 || msg_status !== 8'hF8 || msg_len !== 2'd0) $display("[TB] FAIL ov_held got v=%0b s=%h l=%0d want v=1 s=f8 l=0", msg_valid, msg_status, msg_len); else passed++;
        msg_ready = 1'b1;
        tick(3);
        checks++; if (accCount - base !== 1) $display("[TB] FAIL ov_count got %0d want 1", accCount - base); else passed++;
        checks++; if (accLog[base] !== pack(8'hF8, 7'h00, 7'h00, 2'd0)) $display("[TB] FAIL ov_msg got %h want %h", accLog[base], pack(8'hF8, 7'h00, 7'h00, 2'd0)); else passed++;
        checks++; if (msg_valid !== 1'b0) $display("[TB] FAIL ov_drain_valid got %0b want 0", msg_valid); else passed++;
    endtask

    task automatic test_sysex;
        int base;
        base = accCount;
        sendByte(8'hC5);
        sendByte(8'h07);
        sendByte(8'hF0);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'hF7);
        sendByte(8'h33);
        tick(40);
        checks++; if (accCount - base !== 1) $display("[TB] FAIL sysex_count got %0d want 1", accCount - base); else passed++;
        checks++; if (accLog[base] !== pack(8'hC5, 7'h07, 7'h00, 2'd1)) $display("[TB] FAIL sysex_msg got %h want %h", accLog[base], pack(8'hC5, 7'h07, 7'h00, 2'd1)); else passed++;
    endtask

    task automatic test_frame_error;
        int base, feBase;
        base   = accCount;
        feBase = feCount;
        sendBits(8'h55, 1'b0);
        tick(40);
        checks++; if (feCount - feBase !== 1) $display("[TB] FAIL fe_pulses got %0d want 1", feCount - feBase); else passed++;
        sendByte(8'h80);
        sendByte(8'h40);
        sendByte(8'h00);
        tick(40);
        checks++; if (accCount - base !== 1) $display("[TB] FAIL fe_count got %0d want 1", accCount - base); else passed++;
        checks++; if (accLog[base] !== pack(8'h80, 7'h40, 7'h00, 2'd2)) $display("[TB] FAIL fe_msg got %h want %h", accLog[base], pack(8'h80, 7'h40, 7'h00, 2'd2)); else passed++;
        checks++; if (feCount - feBase !== 1) $display("[TB] FAIL fe_total got %0d want 1", feCount - feBase); else passed++;
    endtask

    task automatic test_glitch;
        int base, feBase;
        base    = accCount;
        feBase  = feCount;
        midi_in = 1'b0;
        tick(10);
        midi_in = 1'b1;
        tick(400);
        checks++; if (accCount - base !== 0) $display("[TB] FAIL glitch_msgs got %0d want 0", accCount - base); else passed++;
        checks++; if (feCount - feBase !== 0) $display("[TB] FAIL glitch_fe got %0d want 0", feCount - feBase); else passed++;
    endtask

    task automatic test_reset_midframe;
        int base;
        logic [7:0] b;
        b         = 8'hF5;
        msg_ready = 1'b0;
        sendByte(8'hF8);
        tick(40);
        checks++; if (msg_valid !== 1'b1) $display("[TB] FAIL rstmid_pre_valid got %0b want 1", msg_valid); else passed++;
        midi_in = 1'b0;
        tick(32);
        for (int i = 0; i < 4; i++) begin
            midi_in = b[i];
            tick(32);
        end
        midi_in = b[4];
        tick(16);
        reset = 1'b1;
        tick(1);
        checks++; if (msg_valid !== 1'b0 || msg_status !== 8'h00 || msg_data1 !== 7'h00 || msg_data2 !== 7'h00 || msg_len !== 2'd0 || frame_err !== 1'b0 || overrun !== 1'b0)
            $display("[TB] FAIL rstmid_outputs got v=%0b s=%h d1=%h d2=%h l=%0d fe=%0b ov=%0b want all 0", msg_valid, msg_status, msg_data1, msg_data2, msg_len, frame_err, overrun);
        else passed++;
        reset     = 1'b0;
        msg_ready = 1'b1;
        tick(16 + 32 * 4 + 20);
        base = accCount;
        sendByte(8'h90);
        sendByte(8'h12);
        sendByte(8'h34);
        tick(40);
        checks++; if (accCount - base !== 1) $display("[TB] FAIL rstmid_count got %0d want 1", accCount - base); else passed++;
        checks++; if (accLog[base] !== pack(8'h90, 7'h12, 7'h34, 2'd2)) $display("[TB] FAIL rstmid_msg got %h want %h", accLog[base], pack(8'h90, 7'h12, 7'h34, 2'd2)); else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        midi_in   = 1'b1;
        msg_ready = 1'b1;
        test_reset();
        test_single_note();
        test_running_status();
        test_realtime();
        test_overrun();
        test_sysex();
        test_frame_error();
        test_glitch();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
